// File: rtl/slot_pkg.sv
// Shared types and helpers for the slot-machine reel sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package slot_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SPIN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] LED_IDLE = 3'b001;
  localparam logic [2:0] LED_SPIN = 3'b010;
  localparam logic [2:0] LED_DONE = 3'b100;

  // Frame count a reel must reach before it is allowed to stop.
  function automatic int frame_limit(input int min_frames, input int stagger, input int idx);
    return min_frames + idx * stagger;
  endfunction

endpackage

// File: rtl/reel_stepper.sv
// One reel: clamped target latch, wrapping symbol counter, moving flag and stop decision.
// Latency: symbol/moving update on the clock edge that samples i_step.
// Backpressure: none; a step is consumed every time it is presented while moving.
module reel_stepper
  import slot_pkg::*;
#(
  parameter int SYM_BITS        = 3,
  parameter int NUM_SYMS        = 8,
  parameter int CNT_W           = 8,
  parameter int REEL_IDX        = 0,
  parameter int MIN_SPIN_FRAMES = 60,
  parameter int STAGGER_FRAMES  = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_load,
  input  logic                i_step,
  input  logic                i_slam,
  input  logic [CNT_W-1:0]    i_frame_cnt,
  input  logic [SYM_BITS-1:0] i_final,
  output logic [SYM_BITS-1:0] o_sym,
  output logic                o_moving
);

  localparam logic [SYM_BITS-1:0] SYM_LAST = SYM_BITS'(NUM_SYMS - 1);
  localparam logic [CNT_W-1:0]    LIMIT    =
    CNT_W'(frame_limit(MIN_SPIN_FRAMES, STAGGER_FRAMES, REEL_IDX));

  logic [SYM_BITS-1:0] r_sym;
  logic [SYM_BITS-1:0] r_target;
  logic                r_moving;

  logic [SYM_BITS-1:0] w_final_clamped;
  logic [SYM_BITS-1:0] w_sym_next;
  logic                w_eligible;

  // Out-of-range targets would never match the strip, so pin them to the last symbol.
  assign w_final_clamped = (i_final > SYM_LAST) ? SYM_LAST : i_final;
  assign w_sym_next      = (r_sym == SYM_LAST) ? '0 : r_sym + SYM_BITS'(1);
  assign w_eligible      = (i_frame_cnt >= LIMIT) || i_slam;

  // Latch target on launch; on each step either stop on the target or advance one symbol.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sym    <= '0;
      r_target <= '0;
      r_moving <= 1'b0;
    end else if (i_load) begin
      r_target <= w_final_clamped;
      r_moving <= 1'b1;
    end else if (i_step && r_moving) begin
      if (w_eligible && (r_sym == r_target)) begin
        r_moving <= 1'b0;
      end else begin
        r_sym <= w_sym_next;
      end
    end
  end

  assign o_sym    = r_sym;
  assign o_moving = r_moving;

endmodule

// File: rtl/slot_reel_sequencer.sv
// Spins NUM_REELS reels one symbol per frame and stops them staggered (or slammed) on latched targets.
// Latency: start edge -> busy next edge; last reel stop -> one-cycle done on the following edge.
// Backpressure: none; start edges outside IDLE and slam outside SPIN are dropped, not queued.
module slot_reel_sequencer
  import slot_pkg::*;
#(
  parameter int NUM_REELS       = 3,
  parameter int SYM_BITS        = 3,
  parameter int NUM_SYMS        = 8,
  parameter int MIN_SPIN_FRAMES = 60,
  parameter int STAGGER_FRAMES  = 20
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_tick,
  input  logic                          start_spin,
  input  logic                          slam_stop,
  input  logic [NUM_REELS*SYM_BITS-1:0] final_sym,
  output logic [NUM_REELS*SYM_BITS-1:0] reel_sym,
  output logic [NUM_REELS-1:0]          reel_moving,
  output logic                          busy,
  output logic                          done,
  output logic [2:0]                    state_led
);

  localparam int FRAME_MAX = frame_limit(MIN_SPIN_FRAMES, STAGGER_FRAMES, NUM_REELS - 1);
  localparam int CNT_W     = $clog2(FRAME_MAX) + 1;
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(FRAME_MAX);

  state_t             r_state;
  state_t             w_state_next;
  logic               r_start_d;
  logic               r_slam;
  logic [CNT_W-1:0]   r_frame_cnt;

  logic               w_start_rise;
  logic               w_load;
  logic               w_step;

  assign w_start_rise = start_spin & ~r_start_d;
  assign w_step       = (r_state == SPIN) && frame_tick;

  // Remember last start_spin level so only a fresh rising edge launches a spin.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_start_d <= 1'b0;
    end else begin
      r_start_d <= start_spin;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: launch from IDLE, finish when every reel has stopped, DONE lasts one cycle.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start_rise) begin
          w_load       = 1'b1;
          w_state_next = SPIN;
        end
      end
      SPIN: begin
        if (reel_moving == '0) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Frame counter: cleared at launch, counts ticks in SPIN, saturates at the last reel's limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_cnt <= '0;
    end else if (w_load) begin
      r_frame_cnt <= '0;
    end else if (w_step && (r_frame_cnt < CNT_SAT)) begin
      r_frame_cnt <= r_frame_cnt + CNT_W'(1);
    end
  end

  // Sticky slam flag; registered, so a slam on a tick only counts from the next tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_slam <= 1'b0;
    end else if (w_load) begin
      r_slam <= 1'b0;
    end else if ((r_state == SPIN) && slam_stop) begin
      r_slam <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REELS; gi++) begin : g_reel
      reel_stepper #(
        .SYM_BITS        (SYM_BITS),
        .NUM_SYMS        (NUM_SYMS),
        .CNT_W           (CNT_W),
        .REEL_IDX        (gi),
        .MIN_SPIN_FRAMES (MIN_SPIN_FRAMES),
        .STAGGER_FRAMES  (STAGGER_FRAMES)
      ) u_reel (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_slam      (r_slam),
        .i_frame_cnt (r_frame_cnt),
        .i_final     (final_sym[gi*SYM_BITS +: SYM_BITS]),
        .o_sym       (reel_sym[gi*SYM_BITS +: SYM_BITS]),
        .o_moving    (reel_moving[gi])
      );
    end
  endgenerate

  assign busy = (r_state == SPIN);
  assign done = (r_state == DONE);

  // Status LEDs decoded purely from the state register.
  always_comb begin
    state_led = LED_IDLE;
    case (r_state)
      IDLE:    state_led = LED_IDLE;
      SPIN:    state_led = LED_SPIN;
      DONE:    state_led = LED_DONE;
      default: state_led = LED_IDLE;
    endcase
  end

endmodule

// File: tb/tb_slot_reel_sequencer.sv
// Directed bench for slot_reel_sequencer: staggered stop table plus wrap, slam, reset, idle and clamp cases.
// Latency: inputs driven on falling edges, outputs sampled on the next falling edge.
// Backpressure: not applicable.
module tb_slot_reel_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       start_spin;
  logic       slam_stop;
  logic [8:0] final_sym;
  logic [8:0] reel_sym;
  logic [2:0] reel_moving;
  logic       busy;
  logic       done;
  logic [2:0] state_led;

  logic       start2;
  logic       slam2;
  logic [8:0] final2;
  logic [8:0] sym2;
  logic [2:0] mov2;
  logic       busy2;
  logic       done2;
  logic [2:0] led2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  slot_reel_sequencer #(
    .NUM_REELS(3), .SYM_BITS(3), .NUM_SYMS(8), .MIN_SPIN_FRAMES(4), .STAGGER_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start_spin(start_spin),
    .slam_stop(slam_stop), .final_sym(final_sym), .reel_sym(reel_sym),
    .reel_moving(reel_moving), .busy(busy), .done(done), .state_led(state_led)
  );

  slot_reel_sequencer #(
    .NUM_REELS(3), .SYM_BITS(3), .NUM_SYMS(6), .MIN_SPIN_FRAMES(4), .STAGGER_FRAMES(2)
  ) dut6 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start_spin(start2),
    .slam_stop(slam2), .final_sym(final2), .reel_sym(sym2),
    .reel_moving(mov2), .busy(busy2), .done(done2), .state_led(led2)
  );

  typedef struct {
    int         ticks;
    logic [8:0] sym;
    logic [2:0] mov;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; frame_tick = 1'b0; start_spin = 1'b0; slam_stop = 1'b0;
    start2 = 1'b0; slam2 = 1'b0;
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic start1();
    @(negedge clk) start_spin = 1'b1;
    @(negedge clk) start_spin = 1'b0;
  endtask

  // Global time bound so a broken design can never hang the run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_ticks;
    int pulses;

    tbl[0] = '{5,  {3'd5, 3'd5, 3'd5}, 3'b111};
    tbl[1] = '{6,  {3'd6, 3'd6, 3'd5}, 3'b110};
    tbl[2] = '{9,  {3'd1, 3'd1, 3'd5}, 3'b110};
    tbl[3] = '{10, {3'd2, 3'd1, 3'd5}, 3'b100};
    tbl[4] = '{15, {3'd7, 3'd1, 3'd5}, 3'b100};
    tbl[5] = '{16, {3'd7, 3'd1, 3'd5}, 3'b000};

    reset = 1'b1; frame_tick = 1'b0; start_spin = 1'b0; slam_stop = 1'b0;
    final_sym = '0; start2 = 1'b0; slam2 = 1'b0; final2 = '0;
    do_reset();

    // Reset state
    chk("rst_sym",  32'(reel_sym), 32'h0);
    chk("rst_mov",  32'(reel_moving), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_led",  32'(state_led), 32'h1);

    // Staggered stop, finals 5,1,7; targets changed and start re-pulsed mid-spin
    final_sym = {3'd7, 3'd1, 3'd5};
    start1();
    chk("stg_busy", 32'(busy), 32'h1);
    chk("stg_led",  32'(state_led), 32'h2);
    tick_n(2);
    chk("stg_sym_t2", 32'(reel_sym), 32'(9'o222));
    @(negedge clk) begin final_sym = '0; start_spin = 1'b1; end
    @(negedge clk) start_spin = 1'b0;
    done_ticks = 2;
    for (int v = 0; v < 6; v++) begin
      tick_n(tbl[v].ticks - done_ticks);
      done_ticks = tbl[v].ticks;
      chk($sformatf("stg_sym_t%0d", tbl[v].ticks), 32'(reel_sym), 32'(tbl[v].sym));
      chk($sformatf("stg_mov_t%0d", tbl[v].ticks), 32'(reel_moving), 32'(tbl[v].mov));
    end
    chk("stg_done_early", 32'(done), 32'h0);
    chk("stg_busy_t16", 32'(busy), 32'h1);
    @(negedge clk);
    chk("stg_done", 32'(done), 32'h1);
    chk("stg_busy_done", 32'(busy), 32'h0);
    chk("stg_led_done", 32'(state_led), 32'h4);
    @(negedge clk);
    chk("stg_done_off", 32'(done), 32'h0);
    chk("stg_led_idle", 32'(state_led), 32'h1);

    // Wrap: finals 0,0,0 all stop together on tick 9
    do_reset();
    final_sym = '0;
    start1();
    tick_n(8);
    chk("wrap_sym_t8", 32'(reel_sym), 32'h0);
    chk("wrap_mov_t8", 32'(reel_moving), 32'h7);
    tick_n(1);
    chk("wrap_sym_t9", 32'(reel_sym), 32'h0);
    chk("wrap_mov_t9", 32'(reel_moving), 32'h0);
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("wrap_done_pulses", 32'(pulses), 32'd1);

    // Slam after one tick: all stop at 2 on tick 3
    do_reset();
    final_sym = {3'd2, 3'd2, 3'd2};
    start1();
    tick_n(1);
    @(negedge clk) slam_stop = 1'b1;
    @(negedge clk) slam_stop = 1'b0;
    tick_n(1);
    chk("slam_sym_t2", 32'(reel_sym), 32'(9'o222));
    chk("slam_mov_t2", 32'(reel_moving), 32'h7);
    tick_n(1);
    chk("slam_mov_t3", 32'(reel_moving), 32'h0);
    chk("slam_sym_t3", 32'(reel_sym), 32'(9'o222));
    chk("slam_busy_t3", 32'(busy), 32'h1);
    @(negedge clk);
    chk("slam_done", 32'(done), 32'h1);
    chk("slam_busy_done", 32'(busy), 32'h0);

    // Reset mid-spin, then a normal spin
    do_reset();
    final_sym = {3'd7, 3'd1, 3'd5};
    start1();
    tick_n(3);
    chk("mid_sym_pre", 32'(reel_sym), 32'(9'o333));
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    chk("mid_sym", 32'(reel_sym), 32'h0);
    chk("mid_led", 32'(state_led), 32'h1);
    chk("mid_done", 32'(done), 32'h0);
    chk("mid_mov", 32'(reel_moving), 32'h0);
    reset = 1'b0;
    start1();
    chk("mid_restart_busy", 32'(busy), 32'h1);
    tick_n(6);
    chk("mid_restart_r0", 32'(reel_sym[2:0]), 32'd5);
    chk("mid_restart_mov", 32'(reel_moving), 32'h6);

    // No frame ticks for 1000 cycles
    do_reset();
    final_sym = {3'd3, 3'd3, 3'd3};
    start1();
    repeat (1000) @(negedge clk);
    chk("idle_sym", 32'(reel_sym), 32'h0);
    chk("idle_busy", 32'(busy), 32'h1);
    chk("idle_mov", 32'(reel_moving), 32'h7);

    // Clamp on a 6-symbol strip: final 7 stops at 5
    do_reset();
    final2 = {3'd7, 3'd7, 3'd7};
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    chk("clamp_busy", 32'(busy2), 32'h1);
    tick_n(11);
    chk("clamp_sym_t11", 32'(sym2), 32'(9'o555));
    chk("clamp_mov_t11", 32'(mov2), 32'h6);
    tick_n(1);
    chk("clamp_sym_t12", 32'(sym2), 32'(9'o555));
    chk("clamp_mov_t12", 32'(mov2), 32'h0);
    @(negedge clk);
    chk("clamp_done", 32'(done2), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
